// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path: receiver and assembly FSM
// state encodings, the frame data width, and the bit-period helper used to
// derive CLKS_PER_BIT from the clock and line rates.
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int BITS_PER_BYTE = 8;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_BREAK
   } rxState_t;

   typedef enum logic [1:0] {
      s_IDLE,
      s_WAIT_RX,
      s_DONE
   } topState_t;

   // Clock cycles per UART bit, truncated.
   function automatic int clksPerBit(input int clkFreq, input int baudRate);
      return clkFreq / baudRate;
   endfunction

endpackage

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first. The line is brought into the iClk domain
// through a two-flop synchroniser and sampled at the middle of each bit.
//
// Ports:
//   iClk     clock
//   iRst     synchronous active-high reset
//   iRx      asynchronous serial line, idle high
//   oRxByte  last received data byte (valid while oRxDone pulses)
//   oRxDone  1-cycle pulse: good frame received
//   oRxErr   1-cycle pulse: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1085
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iRx,
   output logic [7:0] oRxByte,
   output logic       oRxDone,
   output logic       oRxErr
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

   rxState_t         rState;
   logic [CNT_W-1:0] rClkCnt;
   logic [2:0]       rBitIdx;
   logic [7:0]       rShift;
   logic             rSync1;
   logic             rSync2;

   assign oRxByte = rShift;

   // Synchronisers reset to the idle level so reset never looks like a start bit.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         rSync1 <= 1'b1;
         rSync2 <= 1'b1;
      end else begin
         rSync1 <= iRx;
         rSync2 <= rSync1;
      end
   end

   // Data shift register carries no reset; it is only read on oRxDone.
   always_ff @(posedge iClk) begin
      if (rState == RX_DATA && rClkCnt == FULL_LAST)
         rShift <= {rSync2, rShift[7:1]};
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         rState  <= RX_IDLE;
         rClkCnt <= '0;
         rBitIdx <= '0;
         oRxDone <= 1'b0;
         oRxErr  <= 1'b0;
      end else begin
         oRxDone <= 1'b0;
         oRxErr  <= 1'b0;
         case (rState)
            RX_IDLE: begin
               rClkCnt <= '0;
               if (!rSync2)
                  rState <= RX_START;
            end
            // Re-check at mid start bit; a high line here was only a glitch.
            RX_START: begin
               if (rClkCnt == HALF_LAST) begin
                  rClkCnt <= '0;
                  rBitIdx <= '0;
                  rState  <= rSync2 ? RX_IDLE : RX_DATA;
               end else begin
                  rClkCnt <= rClkCnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rClkCnt == FULL_LAST) begin
                  rClkCnt <= '0;
                  rBitIdx <= rBitIdx + 1'b1;
                  if (rBitIdx == 3'(BITS_PER_BYTE - 1))
                     rState <= RX_STOP;
               end else begin
                  rClkCnt <= rClkCnt + 1'b1;
               end
            end
            // Leaving at mid stop bit leaves half a bit to catch a
            // back-to-back start edge.
            RX_STOP: begin
               if (rClkCnt == FULL_LAST) begin
                  rClkCnt <= '0;
                  if (rSync2) begin
                     oRxDone <= 1'b1;
                     rState  <= RX_IDLE;
                  end else begin
                     oRxErr  <= 1'b1;
                     rState  <= RX_BREAK;
                  end
               end else begin
                  rClkCnt <= rClkCnt + 1'b1;
               end
            end
            // Line held low (break): wait for idle before hunting for a start.
            RX_BREAK: begin
               if (rSync2)
                  rState <= RX_IDLE;
            end
            default: rState <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_top_receive.sv
// -----------------------------------------------------------------------------
// uart_top_receive
// Receives NBYTES UART frames and assembles them into one word, first byte
// in the uppermost position. The full word is flagged on oValid and held
// until the host acknowledges with iAck.
//
// Ports:
//   iClk       clock
//   iRst       synchronous active-high reset
//   iRx        serial line, idle high, 8N1 LSB first
//   iAck       consumer acknowledge; re-arms the receiver while oValid=1
//   oBuffer    assembled word (partial contents visible during filling)
//   oValid     high while the buffer is full and unacknowledged
//   oFrameErr  sticky framing-error flag, cleared by iAck
// -----------------------------------------------------------------------------
module uart_top_receive
   import uart_pkg::*;
#(
   parameter int NBYTES    = 8,
   parameter int CLK_FREQ  = 125_000_000,
   parameter int BAUD_RATE = 115_200
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iRx,
   input  logic                iAck,
   output logic [NBYTES*8-1:0] oBuffer,
   output logic                oValid,
   output logic                oFrameErr
);

   localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W        = $clog2(NBYTES) + 1;

   topState_t           rState;
   logic [NBYTES*8-1:0] rBuffer;
   logic [CNT_W-1:0]    rCnt;
   logic [7:0]          wRxByte;
   logic                wRxDone;
   logic                wRxErr;
   logic                wAckNow;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uRx (
      .iClk    (iClk),
      .iRst    (iRst),
      .iRx     (iRx),
      .oRxByte (wRxByte),
      .oRxDone (wRxDone),
      .oRxErr  (wRxErr)
   );

   assign oBuffer = rBuffer;
   assign wAckNow = (rState == s_DONE) && iAck;

   always_ff @(posedge iClk) begin
      if (iRst) begin
         rState    <= s_IDLE;
         rBuffer   <= '0;
         rCnt      <= '0;
         oValid    <= 1'b0;
         oFrameErr <= 1'b0;
      end else begin
         case (rState)
            s_IDLE: rState <= s_WAIT_RX;
            s_WAIT_RX: begin
               if (wRxDone) begin
                  rBuffer <= {rBuffer[NBYTES*8-9:0], wRxByte};
                  rCnt    <= rCnt + CNT_W'(1);
                  if (rCnt == CNT_W'(NBYTES - 1)) begin
                     rState <= s_DONE;
                     oValid <= 1'b1;
                  end
               end
            end
            // Word held; new bytes are dropped until acknowledged.
            s_DONE: begin
               if (iAck) begin
                  rBuffer   <= '0;
                  rCnt      <= '0;
                  oValid    <= 1'b0;
                  oFrameErr <= 1'b0;
                  rState    <= s_WAIT_RX;
               end
            end
            default: begin
               rState <= s_IDLE;
               oValid <= 1'b0;
            end
         endcase
         // An ack in the same cycle as a framing error leaves the flag clear.
         if (wRxErr && !wAckNow)
            oFrameErr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_top_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_top_receive
// Self-checking bench for uart_top_receive. Frames are bit-banged onto iRx
// and the expected word/flags are tracked by a byte-level model.
// -----------------------------------------------------------------------------
module tb_uart_top_receive;

   localparam int NBYTES    = 8;
   localparam int CLK_FREQ  = 1_000_000;
   localparam int BAUD_RATE = 100_000;
   localparam int CPB       = CLK_FREQ / BAUD_RATE;

   logic                iClk = 1'b0;
   logic                iRst;
   logic                iRx;
   logic                iAck;
   logic [NBYTES*8-1:0] oBuffer;
   logic                oValid;
   logic                oFrameErr;

   int nChecks = 0;
   int nErrors = 0;

   // Reference model: word contents, byte count, valid and error flags.
   logic [NBYTES*8-1:0] mBuf;
   int                  mCnt;
   logic                mValid;
   logic                mErr;

   logic [7:0] bytes1 [NBYTES] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hEF, 8'hCD, 8'hAB, 8'h90};
   localparam logic [63:0] WORD1 = 64'h12345678_EFCDAB90;

   always #5 iClk = ~iClk;

   uart_top_receive #(
      .NBYTES    (NBYTES),
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) dut (
      .iClk      (iClk),
      .iRst      (iRst),
      .iRx       (iRx),
      .iAck      (iAck),
      .oBuffer   (oBuffer),
      .oValid    (oValid),
      .oFrameErr (oFrameErr)
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic checkState(input string tag);
      checkVal({tag, ".buf"}, 64'(oBuffer), 64'(mBuf));
      checkVal({tag, ".vld"}, 64'(oValid), 64'(mValid));
      checkVal({tag, ".err"}, 64'(oFrameErr), 64'(mErr));
   endtask

   task automatic modelClear();
      mBuf   = '0;
      mCnt   = 0;
      mValid = 1'b0;
      mErr   = 1'b0;
   endtask

   task automatic modelByte(input logic [7:0] b);
      if (!mValid) begin
         mBuf = {mBuf[NBYTES*8-9:0], b};
         mCnt++;
         if (mCnt == NBYTES) mValid = 1'b1;
      end
   endtask

   task automatic holdRx(input logic v, input int cycles);
      iRx = v;
      repeat (cycles) @(negedge iClk);
   endtask

   task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int idleBits);
      holdRx(1'b0, CPB);
      for (int i = 0; i < 8; i++) holdRx(b[i], CPB);
      // The frame is not complete yet, so the flag must still show the old state.
      checkVal("vld_pre_stop", 64'(oValid), 64'(mValid));
      holdRx(stopBit, CPB);
      if (stopBit) modelByte(b);
      else         mErr = 1'b1;
      if (idleBits > 0) holdRx(1'b1, idleBits * CPB);
   endtask

   task automatic sendRandom(input int n, input int idleBits);
      for (int i = 0; i < n; i++) sendFrame(8'($urandom_range(0, 255)), 1'b1, idleBits);
   endtask

   task automatic sendWord1();
      for (int i = 0; i < NBYTES; i++) sendFrame(bytes1[i], 1'b1, 1);
   endtask

   task automatic pulseAck();
      iAck = 1'b1;
      @(negedge iClk);
      iAck = 1'b0;
      if (mValid) modelClear();
   endtask

   initial begin
      iRst = 1'b1;
      iRx  = 1'b1;
      iAck = 1'b0;
      modelClear();
      repeat (3) @(negedge iClk);
      iRst = 1'b0;
      checkState("reset");
      holdRx(1'b1, 10 * CPB);

      // Fixed word, with a look at partial contents along the way.
      for (int i = 0; i < NBYTES; i++) begin
         sendFrame(bytes1[i], 1'b1, 1);
         if (i == 2) checkState("t1.partial");
      end
      checkState("t1");
      checkVal("t1.word", 64'(oBuffer), WORD1);
      pulseAck();
      checkState("t1.ack");

      // Start-bit glitch must produce nothing.
      holdRx(1'b0, 3);
      holdRx(1'b1, 2 * CPB);
      checkState("t2.glitch");
      sendWord1();
      checkState("t2");
      checkVal("t2.word", 64'(oBuffer), WORD1);
      pulseAck();

      // Framing error: byte discarded, sticky flag set until ack.
      sendFrame(8'h55, 1'b0, 2);
      checkState("t3.err");
      sendWord1();
      checkState("t3");
      checkVal("t3.word", 64'(oBuffer), WORD1);
      pulseAck();
      checkState("t3.ack");

      // Byte while full is dropped; ack while not full is ignored.
      sendRandom(NBYTES, 1);
      checkState("t4.full");
      sendFrame(8'hFF, 1'b1, 1);
      checkState("t4.drop");
      pulseAck();
      checkState("t4.ack");
      sendRandom(4, 1);
      pulseAck();
      checkState("t4.ignack");
      sendRandom(NBYTES - 4, 1);
      checkState("t4.refill");
      pulseAck();

      // Reset part way through a word.
      sendRandom(3, 1);
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
      modelClear();
      checkState("t5.rst");
      holdRx(1'b1, 10 * CPB);
      sendRandom(NBYTES, 1);
      checkState("t5");
      pulseAck();

      // Back-to-back frames with no idle time.
      sendRandom(NBYTES, 0);
      checkState("t6");
      pulseAck();
      checkState("t6.ack");

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule

// File: doc/uart_top_receive.md
# uart_top_receive

Receive-side counterpart of the UART byte-stream sender. It deserialises NBYTES UART frames from iRx and assembles them into one NBYTES*8-bit buffer, placing the first byte received in the uppermost byte. When the buffer is full it presents the word with a valid flag and holds it until the host logic acknowledges. This makes a host-to-FPGA vector transfer the mirror image of the FPGA-to-host send path.

## Interface
- NBYTES, 8: number of bytes per buffer
- CLK_FREQ, 125_000_000: iClk frequency in Hz
- BAUD_RATE, 115_200: line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, truncated (1085 at defaults)

- iClk  in  1  clock
- iRst  in  1  reset, synchronous, active-high
- iRx  in  1  asynchronous serial line, idle high, 8N1, LSB first
- iAck  in  1  consumer acknowledge; re-arms the receiver while oValid=1
- oBuffer  out  NBYTES*8  assembled word; reset 0
- oValid  out  1  level, high while the buffer is full and unacknowledged; reset 0
- oFrameErr  out  1  sticky, set when a stop bit is sampled low; reset 0

## Operation
- Sub-module uart_rx supplies:
  - oRxByte[7:0]
  - oRxDone: 1-cycle pulse for a good frame
  - oRxErr: 1-cycle pulse for a framing error
- uart_rx synchronises iRx through 2 FFs, both reset to 1, and runs the states below.
  - RX_IDLE: a synced low starts the counter and moves to RX_START.
  - RX_START: waits CLKS_PER_BIT/2 cycles, then re-samples. Low moves to RX_DATA. High is a glitch and returns to RX_IDLE with no output.
  - RX_DATA: samples every CLKS_PER_BIT cycles, 8 bits, LSB into bit 0 first.
  - RX_STOP: waits CLKS_PER_BIT cycles, then samples the stop bit.
    - High: pulse oRxDone and return to RX_IDLE at mid-stop-bit, so back-to-back frames are caught.
    - Low: pulse oRxErr, then wait until the synced line is high before entering RX_IDLE (break handling).
- Top FSM states:
  - s_IDLE: one cycle after reset, then s_WAIT_RX.
  - s_WAIT_RX:
    - On oRxDone: rBuffer <= {rBuffer[NBYTES*8-9:0], oRxByte} and rCnt+1.
    - When rCnt==NBYTES-1 on that pulse: go to s_DONE.
  - s_DONE:
    - oValid=1; oBuffer is stable. Any further received byte is dropped.
    - On iAck: rBuffer<=0, rCnt<=0, oFrameErr<=0, then s_WAIT_RX.
  - Any other state value returns to s_IDLE.
- oRxErr: sets oFrameErr in any state. The byte is discarded and rCnt is unchanged.
- oBuffer is driven directly from rBuffer, so partial contents are visible during filling.
- rCnt width is $clog2(NBYTES)+1.

## Timing
- Start detection lags the iRx falling edge by 2-3 cycles (synchroniser).
- oRxDone fires about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the start-bit falling edge.
- oValid rises on the cycle after the final byte's oRxDone pulse. oBuffer holds the final value from that same edge.
- oValid falls on the cycle after iAck is sampled high. iAck while oValid=0 is ignored.
- Simultaneous events:
  - iAck and oRxDone in the same s_DONE cycle: the ack wins and the byte is dropped.
  - oRxErr and iAck in the same cycle: oFrameErr ends at 0.
- Reset mid-frame: every register returns to its reset value on the next edge. The bench must idle iRx high for at least 10 bit periods after reset before sending again.

## Structure
- Shared package uart_pkg holds:
  - rx/top state localparams
  - CLKS_PER_BIT as a function of CLK_FREQ and BAUD_RATE
  - bit-count constant 8
- One sub-module, uart_rx, forms the receiver pair with the existing uart_tx. The top holds only the assembly FSM.

## Test plan
Sim parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clks/bit), NBYTES=8.
- Send frames 12,34,56,78,EF,CD,AB,90 (hex) -> oBuffer=64'h12345678_EFCDAB90, oValid=1 one cycle after the 8th oRxDone, oFrameErr=0.
- Pulse iRx low for 3 cycles, then send the 8 bytes -> the glitch produces no byte, and the result is the same as the first test.
- Send 0x55 with stop bit=0, then the 8 good bytes -> oFrameErr=1, 0x55 is absent, and the buffer equals the first result.
- While oValid=1, send 0xFF, then pulse iAck -> 0xFF is ignored; next cycle oValid=0, oBuffer=0, oFrameErr=0. The next 8 bytes fill a new word.
- After 3 bytes, assert iRst for 1 cycle -> oBuffer=0, oValid=0, rCnt=0. After 10 idle bits, 8 new bytes assemble correctly.
- Send 8 back-to-back frames with no idle bits between stop and start -> all captured, oBuffer matches the sent order.
